// File: rtl/envelope_follower_if.sv
// rtl/envelope_follower_if.sv - sample-in / envelope-out bundle for envelope_follower
//
// Purpose: groups the sample strobe input and the registered envelope
// results into one bundle.
//   sample_in  signed 16-bit sample, valid while in_ready=1
//   in_ready   one-cycle sample strobe (may repeat on consecutive cycles)
//   envelope   unsigned envelope level 0..32767
//   env_valid  one-cycle pulse: outputs updated
//   gate       note-active flag with hysteresis
//   phase      0 IDLE, 1 ATTACK, 2 HOLD, 3 RELEASE
//   note_len   gate-high sample count of the last completed note
//   note_done  one-cycle pulse on gate fall
// master = sample source / result consumer, slave = envelope_follower.
`timescale 1ns/1ps
interface envelope_follower_if;
  logic signed [15:0] sample_in;
  logic               in_ready;
  logic        [15:0] envelope;
  logic               env_valid;
  logic               gate;
  logic         [1:0] phase;
  logic        [15:0] note_len;
  logic               note_done;

  modport master (
    output sample_in, in_ready,
    input  envelope, env_valid, gate, phase, note_len, note_done
  );

  modport slave (
    input  sample_in, in_ready,
    output envelope, env_valid, gate, phase, note_len, note_done
  );
endinterface

// File: rtl/envelope_follower.sv
// rtl/envelope_follower.sv - amplitude envelope follower with gate, phase and note length
//
// Purpose: tracks the amplitude envelope of a signed 16-bit sample stream.
// Fast attack toward |sample|, hold after the last peak, then exponential
// release. A hysteresis gate marks notes, and the length of each finished
// note is reported.
// Ports:
//   clk    system clock
//   reset  asynchronous reset, active-high
//   bus    envelope_follower_if.slave (sample strobe in, registered results out)
`timescale 1ns/1ps
module envelope_follower #(
  parameter int unsigned ATTACK_SHIFT  = 2,
  parameter int unsigned RELEASE_SHIFT = 4,
  parameter int unsigned HOLD_SAMPLES  = 480,
  parameter int unsigned GATE_ON       = 2048,
  parameter int unsigned GATE_OFF      = 1024
) (
  input  logic                 clk,
  input  logic                 reset,
  envelope_follower_if.slave   bus
);

  typedef enum logic [1:0] {
    PH_IDLE    = 2'd0,
    PH_ATTACK  = 2'd1,
    PH_HOLD    = 2'd2,
    PH_RELEASE = 2'd3
  } phase_e;

  localparam logic [15:0] HOLD_INIT = 16'(HOLD_SAMPLES);
  localparam logic [16:0] GATE_ON_V = 17'(GATE_ON);
  localparam logic [16:0] GATE_OFF_V = 17'(GATE_OFF);

  phase_e      phase_q, phase_d;
  logic [15:0] env_q, env_d;
  logic [15:0] hold_q, hold_d;
  logic        gate_q, gate_d;
  logic [15:0] cnt_q, cnt_d;
  logic [15:0] len_q, len_d;
  logic        valid_q, valid_d;
  logic        done_q, done_d;

  logic [15:0] neg;
  logic [16:0] mag;
  logic [16:0] env_ext;
  logic [16:0] diff;
  logic [16:0] rise_step;
  logic [16:0] fall_step;
  logic [16:0] env_next;

  // |sample|; -32768 has no positive 16-bit counterpart and clips to 32767.
  assign neg     = ~bus.sample_in + 16'd1;
  assign env_ext = {1'b0, env_q};

  always_comb begin
    mag = {1'b0, bus.sample_in};
    if (bus.sample_in == 16'sh8000) begin
      mag = 17'd32767;
    end else if (bus.sample_in[15]) begin
      mag = {1'b0, neg};
    end
  end

  // Step sizes never drop below 1 so the envelope always converges.
  always_comb begin
    diff      = mag - env_ext;
    rise_step = diff >> ATTACK_SHIFT;
    if (rise_step == 17'd0) rise_step = 17'd1;
    fall_step = env_ext >> RELEASE_SHIFT;
    if (fall_step == 17'd0) fall_step = 17'd1;
  end

  always_comb begin
    phase_d  = phase_q;
    env_d    = env_q;
    hold_d   = hold_q;
    gate_d   = gate_q;
    cnt_d    = cnt_q;
    len_d    = len_q;
    valid_d  = 1'b0;
    done_d   = 1'b0;
    env_next = env_ext;

    if (bus.in_ready) begin
      valid_d = 1'b1;

      if (mag > env_ext) begin
        env_next = env_ext + rise_step;
        if (env_next > mag) env_next = mag;
        hold_d  = HOLD_INIT;
        phase_d = PH_ATTACK;
      end else if (mag == env_ext) begin
        if (env_ext != 17'd0) begin
          hold_d  = HOLD_INIT;
          phase_d = PH_HOLD;
        end else begin
          phase_d = PH_IDLE;
        end
      end else if (hold_q != 16'd0) begin
        hold_d  = hold_q - 16'd1;
        phase_d = PH_HOLD;
      end else begin
        env_next = (env_ext > fall_step) ? (env_ext - fall_step) : 17'd0;
        phase_d  = (env_next == 17'd0) ? PH_IDLE : PH_RELEASE;
      end

      env_d = env_next[15:0];

      // Hysteresis on the freshly computed envelope.
      if (!gate_q && env_next >= GATE_ON_V) begin
        gate_d = 1'b1;
      end else if (gate_q && env_next < GATE_OFF_V) begin
        gate_d = 1'b0;
      end

      // The rising sample counts as 1; the falling sample is not counted.
      if (gate_d && !gate_q) begin
        cnt_d = 16'd1;
      end else if (gate_d && gate_q) begin
        if (cnt_q != 16'hFFFF) cnt_d = cnt_q + 16'd1;
      end else if (!gate_d && gate_q) begin
        len_d  = cnt_q;
        done_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      phase_q <= PH_IDLE;
      env_q   <= 16'd0;
      hold_q  <= 16'd0;
      gate_q  <= 1'b0;
      cnt_q   <= 16'd0;
      len_q   <= 16'd0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      phase_q <= phase_d;
      env_q   <= env_d;
      hold_q  <= hold_d;
      gate_q  <= gate_d;
      cnt_q   <= cnt_d;
      len_q   <= len_d;
      valid_q <= valid_d;
      done_q  <= done_d;
    end
  end

  assign bus.envelope  = env_q;
  assign bus.env_valid = valid_q;
  assign bus.gate      = gate_q;
  assign bus.phase     = phase_q;
  assign bus.note_len  = len_q;
  assign bus.note_done = done_q;

endmodule

// File: tb/tb_envelope_follower.sv
// tb/tb_envelope_follower.sv - self-checking bench for envelope_follower
`timescale 1ns/1ps
module tb_envelope_follower;

  localparam int AS    = 2;
  localparam int RS    = 4;
  localparam int HOLD  = 480;
  localparam int G_ON  = 2048;
  localparam int G_OFF = 1024;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  envelope_follower_if bus();

  envelope_follower #(
    .ATTACK_SHIFT (AS),
    .RELEASE_SHIFT(RS),
    .HOLD_SAMPLES (HOLD),
    .GATE_ON      (G_ON),
    .GATE_OFF     (G_OFF)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  int total = 0;
  int bad   = 0;

  int m_env, m_hold, m_phase, m_gate, m_cnt, m_len, m_done;

  task automatic model_reset();
    m_env = 0; m_hold = 0; m_phase = 0; m_gate = 0;
    m_cnt = 0; m_len = 0; m_done = 0;
  endtask

  task automatic model_step(input int s);
    int mag, step, prev;
    mag = (s < 0) ? -s : s;
    if (mag > 32767) mag = 32767;
    if (mag > m_env) begin
      step = (mag - m_env) / (1 << AS);
      if (step < 1) step = 1;
      m_env = (m_env + step > mag) ? mag : m_env + step;
      m_hold = HOLD; m_phase = 1;
    end else if (mag == m_env && m_env > 0) begin
      m_hold = HOLD; m_phase = 2;
    end else if (mag < m_env && m_hold > 0) begin
      m_hold--; m_phase = 2;
    end else if (mag < m_env) begin
      step = m_env / (1 << RS);
      if (step < 1) step = 1;
      m_env = (m_env - step < 0) ? 0 : m_env - step;
      m_phase = (m_env == 0) ? 0 : 3;
    end else begin
      m_phase = 0;
    end
    prev = m_gate;
    if (m_gate == 0 && m_env >= G_ON) m_gate = 1;
    else if (m_gate == 1 && m_env < G_OFF) m_gate = 0;
    m_done = 0;
    if (m_gate == 1 && prev == 0) m_cnt = 1;
    else if (m_gate == 1 && prev == 1) m_cnt = (m_cnt < 65535) ? m_cnt + 1 : 65535;
    else if (m_gate == 0 && prev == 1) begin
      m_len = m_cnt; m_done = 1;
    end
  endtask

  // Drives one strobe and returns 1 ns after the capturing edge.
  task automatic strobe(input int s);
    @(negedge clk);
    bus.in_ready  = 1'b1;
    bus.sample_in = 16'(s);
    model_step(s);
    @(posedge clk);
    #1;
    bus.in_ready = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    bus.in_ready = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    model_reset();
  endtask

  task automatic test_reset();
    #1;
    total++;
    if ({bus.envelope, bus.gate, bus.phase, bus.note_len, bus.note_done, bus.env_valid} !== 36'd0) begin
      bad++;
      $display("FAIL reset_state: env=%0d gate=%0d phase=%0d len=%0d done=%0d valid=%0d required all 0",
               bus.envelope, bus.gate, bus.phase, bus.note_len, bus.note_done, bus.env_valid);
    end
    @(negedge clk);
    reset = 1'b0;
    model_reset();
  endtask

  task automatic test_attack();
    int exp_env[3] = '{4096, 7168, 9472};
    do_reset();
    for (int i = 0; i < 3; i++) begin
      strobe(16384);
      total++;
      if (bus.envelope !== 16'(exp_env[i]) || bus.gate !== 1'b1 || bus.phase !== 2'd1 || bus.env_valid !== 1'b1) begin
        bad++;
        $display("FAIL attack_%0d: env=%0d gate=%0d phase=%0d valid=%0d required env=%0d gate=1 phase=1 valid=1",
                 i, bus.envelope, bus.gate, bus.phase, bus.env_valid, exp_env[i]);
      end
      @(posedge clk);
      #1;
      total++;
      if (bus.env_valid !== 1'b0) begin
        bad++;
        $display("FAIL attack_pulse_%0d: env_valid=%0d required 0", i, bus.env_valid);
      end
    end
  endtask

  task automatic test_saturation();
    do_reset();
    strobe(-32768);
    total++;
    if (bus.envelope !== 16'd8191 || bus.phase !== 2'd1) begin
      bad++;
      $display("FAIL saturation: env=%0d phase=%0d required env=8191 phase=1", bus.envelope, bus.phase);
    end
  endtask

  task automatic test_hold_release();
    int errs = 0;
    do_reset();
    strobe(16384);
    for (int i = 0; i < HOLD; i++) begin
      strobe(0);
      if (bus.envelope !== 16'd4096 || bus.phase !== 2'd2) begin
        if (errs == 0)
          $display("FAIL hold_%0d: env=%0d phase=%0d required env=4096 phase=2", i, bus.envelope, bus.phase);
        errs++;
      end
    end
    total++;
    if (errs != 0) bad++;
    strobe(0);
    total++;
    if (bus.envelope !== 16'd3840 || bus.phase !== 2'd3) begin
      bad++;
      $display("FAIL release_first: env=%0d phase=%0d required env=3840 phase=3", bus.envelope, bus.phase);
    end
  endtask

  task automatic test_min_steps();
    do_reset();
    strobe(60);
    for (int i = 0; i < HOLD; i++) strobe(0);
    total++;
    if (bus.envelope !== 16'd15) begin
      bad++;
      $display("FAIL min_pre15: env=%0d required 15", bus.envelope);
    end
    strobe(0);
    total++;
    if (bus.envelope !== 16'd14) begin
      bad++;
      $display("FAIL min_release: env=%0d required 14", bus.envelope);
    end
    do_reset();
    strobe(400);
    strobe(102);
    total++;
    if (bus.envelope !== 16'd101) begin
      bad++;
      $display("FAIL min_attack: env=%0d required 101", bus.envelope);
    end
    do_reset();
    strobe(4);
    for (int i = 0; i < HOLD; i++) strobe(0);
    strobe(0);
    total++;
    if (bus.envelope !== 16'd0 || bus.phase !== 2'd0) begin
      bad++;
      $display("FAIL min_to_idle: env=%0d phase=%0d required env=0 phase=0", bus.envelope, bus.phase);
    end
  endtask

  task automatic test_gate_note();
    int high_cnt = 0;
    int done_cnt = 0;
    int mid_err  = 0;
    int n        = 0;
    do_reset();
    for (int i = 0; i < 3; i++) begin
      strobe(16384);
      if (bus.gate === 1'b1) high_cnt++;
      if (bus.note_done === 1'b1) done_cnt++;
    end
    while (bus.gate === 1'b1 && n < 2000) begin
      strobe(0);
      n++;
      if (bus.gate === 1'b1) high_cnt++;
      if (bus.note_done === 1'b1) done_cnt++;
      if (bus.envelope >= 16'd1024 && bus.envelope < 16'd2048 && bus.gate !== 1'b1) mid_err++;
    end
    total++;
    if (n >= 2000) begin
      bad++;
      $display("FAIL gate_fall_timeout: gate=%0d after %0d strobes required 0", bus.gate, n);
    end
    total++;
    if (mid_err != 0) begin
      bad++;
      $display("FAIL gate_hysteresis: %0d strobes with env in 1024..2047 and gate=0 required 0", mid_err);
    end
    total++;
    if (done_cnt != 1 || bus.note_done !== 1'b1) begin
      bad++;
      $display("FAIL note_done: pulses=%0d last=%0d required pulses=1 last=1", done_cnt, bus.note_done);
    end
    total++;
    if (bus.note_len !== 16'(high_cnt)) begin
      bad++;
      $display("FAIL note_len: got=%0d required=%0d", bus.note_len, high_cnt);
    end
    strobe(0);
    total++;
    if (bus.note_done !== 1'b0 || bus.note_len !== 16'(high_cnt)) begin
      bad++;
      $display("FAIL note_len_hold: done=%0d len=%0d required done=0 len=%0d", bus.note_done, bus.note_len, high_cnt);
    end
  endtask

  task automatic test_back_to_back();
    int errs = 0;
    do_reset();
    for (int i = 0; i < 6; i++) begin
      strobe((i % 2 == 0) ? 20000 : -3000);
      if (bus.env_valid !== 1'b1 || bus.envelope !== 16'(m_env)) begin
        if (errs == 0)
          $display("FAIL back_to_back_%0d: valid=%0d env=%0d required valid=1 env=%0d",
                   i, bus.env_valid, bus.envelope, m_env);
        errs++;
      end
    end
    total++;
    if (errs != 0) bad++;
  endtask

  task automatic test_reset_hold();
    do_reset();
    strobe(16384);
    for (int i = 0; i < 5; i++) strobe(0);
    total++;
    if (bus.phase !== 2'd2 || bus.gate !== 1'b1) begin
      bad++;
      $display("FAIL pre_reset_hold: phase=%0d gate=%0d required phase=2 gate=1", bus.phase, bus.gate);
    end
    @(posedge clk);
    #2;
    bus.in_ready  = 1'b1;
    bus.sample_in = 16'sd16384;
    reset = 1'b1;
    #1;
    total++;
    if ({bus.envelope, bus.gate, bus.phase, bus.note_len, bus.note_done, bus.env_valid} !== 36'd0) begin
      bad++;
      $display("FAIL async_reset: env=%0d gate=%0d phase=%0d len=%0d done=%0d valid=%0d required all 0",
               bus.envelope, bus.gate, bus.phase, bus.note_len, bus.note_done, bus.env_valid);
    end
    @(posedge clk);
    #1;
    total++;
    if (bus.envelope !== 16'd0 || bus.env_valid !== 1'b0) begin
      bad++;
      $display("FAIL reset_drops_strobe: env=%0d valid=%0d required env=0 valid=0", bus.envelope, bus.env_valid);
    end
    @(negedge clk);
    reset = 1'b0;
    bus.in_ready = 1'b0;
    model_reset();
    strobe(16384);
    total++;
    if (bus.envelope !== 16'd4096 || bus.note_done !== 1'b0 || bus.note_len !== 16'd0) begin
      bad++;
      $display("FAIL after_reset: env=%0d done=%0d len=%0d required env=4096 done=0 len=0",
               bus.envelope, bus.note_done, bus.note_len);
    end
  endtask

  task automatic test_random();
    int errs = 0;
    int s;
    do_reset();
    for (int seg = 0; seg < 6; seg++) begin
      int burst = $urandom_range(1, 20);
      int quiet = $urandom_range(0, 600);
      for (int i = 0; i < burst + quiet; i++) begin
        if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(posedge clk);
        if (i < burst) s = int'($urandom_range(0, 65535)) - 32768;
        else s = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 200)) - 100 : 0;
        strobe(s);
        total++;
        if (bus.envelope !== 16'(m_env) || bus.phase !== 2'(m_phase) || bus.gate !== 1'(m_gate) ||
            bus.note_len !== 16'(m_len) || bus.note_done !== 1'(m_done) || bus.env_valid !== 1'b1) begin
          bad++;
          if (errs < 10)
            $display("FAIL random_seg%0d_%0d: env=%0d ph=%0d gate=%0d len=%0d done=%0d valid=%0d required env=%0d ph=%0d gate=%0d len=%0d done=%0d valid=1",
                     seg, i, bus.envelope, bus.phase, bus.gate, bus.note_len, bus.note_done, bus.env_valid,
                     m_env, m_phase, m_gate, m_len, m_done);
          errs++;
        end
      end
    end
  endtask

  initial begin
    reset         = 1'b1;
    bus.in_ready  = 1'b0;
    bus.sample_in = 16'sd0;
    model_reset();
    test_reset();
    test_attack();
    test_saturation();
    test_hold_release();
    test_min_steps();
    test_gate_note();
    test_back_to_back();
    test_reset_hold();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
